mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 2: maximum granted-but-unanswered memory transactions (1..4).
REQ-002 SHALL have parameter STARVE_LIMIT, default 4: consecutive data grants tolerated while instr waits (1..15).
REQ-003 SHALL have clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have instr_req_i  input  1  fetch request (read only).
REQ-006 SHALL have instr_addr_i  input  32  fetch address.
REQ-007 SHALL have instr_gnt_o  output  1  fetch request accepted this cycle.
REQ-008 SHALL have instr_rvalid_o  output  1  fetch response valid.
REQ-009 SHALL have instr_rdata_o  output  32  fetch response data.
REQ-010 SHALL have instr_err_o  output  1  fetch response error, qualified by instr_rvalid_o.
REQ-011 SHALL have data_req_i  input  1  load/store request.
REQ-012 SHALL have data_we_i  input  1  1 = store.
REQ-013 SHALL have data_be_i  input  4  byte enables.
REQ-014 SHALL have data_addr_i  input  32  load/store address.
REQ-015 SHALL have data_wdata_i  input  32  store data.
REQ-016 SHALL have data_gnt_o  output  1  load/store accepted this cycle.
REQ-017 SHALL have data_rvalid_o  output  1  load/store response valid.
REQ-018 SHALL have data_rdata_o  output  32  load data.
REQ-019 SHALL have data_err_o  output  1  load/store error, qualified by data_rvalid_o.
REQ-020 SHALL have mem_req_o, mem_we_o  output  1 each  shared bus request / write.
REQ-021 SHALL have mem_be_o  output  4  shared bus byte enables.
REQ-022 SHALL have mem_addr_o, mem_wdata_o  output  32 each  shared bus address / write data.
REQ-023 SHALL have mem_gnt_i, mem_rvalid_i, mem_err_i  input  1 each  bus grant / response valid / error.
REQ-024 SHALL have mem_rdata_i  input  32  bus response data.

Function
REQ-025 Owner selection when unlocked: data wins if both request, except instr wins when starve counter == STARVE_LIMIT; only one requesting -> that one; none -> owner = instr, mem_req_o = 0.
REQ-026 mem_req_o = owner's req AND outstanding count < MAX_OUTSTANDING (registered count, no same-cycle pop bypass); zero-cycle combinational path.
REQ-027 mem_addr/we/be/wdata SHALL mux from owner; instr owner drives we = 0, be = 4'hF, wdata = 0.
REQ-028 Lock: mem_req_o = 1 and mem_gnt_i = 0 -> owner registered and held next cycle regardless of other requests; lock clears on cycle of mem_gnt_i = 1.
REQ-029 Grant: owner's gnt_o = mem_req_o & mem_gnt_i; non-owner gnt_o = 0.
REQ-030 ID FIFO, depth MAX_OUTSTANDING, in-order: push owner ID on mem_req_o & mem_gnt_i; pop head on mem_rvalid_i; push and pop same cycle -> count unchanged.
REQ-031 Response routing: mem_rvalid_i drives rvalid_o of FIFO-head ID only; rdata_o/err_o of both ports = mem_rdata_i/mem_err_i (valid only on routed port); zero-cycle.
REQ-032 mem_rvalid_i with count = 0 SHALL be dropped: no rvalid_o, no count underflow.
REQ-033 Starve counter: +1 (saturating at STARVE_LIMIT) on data grant with instr_req_i high; cleared on instr grant or instr_req_i low.
REQ-034 Responses may arrive the cycle after grant or later; the grant cycle's response is never routed (FIFO push takes effect next cycle).

Reset
REQ-035 rst high SHALL, at the next edge, clear count, FIFO, lock and starve counter and set owner = instr; while rst high mem_req_o, *_gnt_o, *_rvalid_o SHALL be 0.
REQ-036 rst mid-transaction SHALL abandon outstanding IDs; responses arriving after reset are dropped per REQ-032.

Verification
V-1 Both request, mem_gnt_i = 1 each cycle -> data granted 4 consecutive cycles, 5th cycle instr granted, counter back to 0.
V-2 instr owns bus, mem_gnt_i = 0 for 3 cycles, data_req_i rises in cycle 2 -> mem_addr_o stays instr_addr_i until gnt; data served afterward.
V-3 Two grants (instr then data), no rvalid -> 3rd request blocked (mem_req_o = 0); rvalid #1 -> instr_rvalid_o; rvalid #2 -> data_rvalid_o, data_rdata_o = mem_rdata_i.
V-4 count = 2, mem_rvalid_i and pending data request same cycle -> no grant that cycle, grant next cycle, count ends 2.
V-5 Stray mem_rvalid_i with count 0 -> both rvalid_o = 0, count stays 0.
V-6 rst asserted with 1 outstanding -> after reset, late mem_rvalid_i ignored, first new instr request granted normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port (fetch / load-store) arbiter onto one shared memory bus with in-order response routing.
// Zero-cycle req/gnt and response paths; holds the owner while mem_gnt_i is low, stalls at MAX_OUTSTANDING.

module mem_arbiter_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_dat,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_dat,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Caller guarantees no push when full and no pop when empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_dat;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_dat = mem_q[rd_ptr_q];
  assign count    = count_q;
endmodule

module mem_arbiter #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int STARVE_LIMIT    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic        mem_err_i,
  input  logic [31:0] mem_rdata_i
);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic {OWN_INSTR = 1'b0, OWN_DATA = 1'b1} owner_e;

  owner_e        owner, lock_owner_q, head_owner;
  logic          lock_q;
  logic [3:0]    starve_q;
  logic          owner_req, bus_gnt, rsp_vld;
  logic          head_id;
  logic [CW-1:0] count;

  // A bus request left hanging without a grant pins the owner until it is accepted.
  always_comb begin
    owner = OWN_INSTR;
    if (lock_q)
      owner = lock_owner_q;
    else if (data_req_i && !(instr_req_i && starve_q == 4'(STARVE_LIMIT)))
      owner = OWN_DATA;
  end

  assign owner_req = (owner == OWN_DATA) ? data_req_i : instr_req_i;
  assign mem_req_o = !rst && owner_req && (count < CW'(MAX_OUTSTANDING));
  assign bus_gnt   = mem_req_o && mem_gnt_i;

  always_comb begin
    mem_addr_o  = instr_addr_i;
    mem_we_o    = 1'b0;
    mem_be_o    = 4'hF;
    mem_wdata_o = '0;
    if (owner == OWN_DATA) begin
      mem_addr_o  = data_addr_i;
      mem_we_o    = data_we_i;
      mem_be_o    = data_be_i;
      mem_wdata_o = data_wdata_i;
    end
  end

  assign instr_gnt_o = bus_gnt && (owner == OWN_INSTR);
  assign data_gnt_o  = bus_gnt && (owner == OWN_DATA);

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q       <= 1'b0;
      lock_owner_q <= OWN_INSTR;
    end else begin
      lock_q       <= mem_req_o && !mem_gnt_i;
      lock_owner_q <= owner;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !instr_req_i || instr_gnt_o)
      starve_q <= '0;
    else if (data_gnt_o && starve_q != 4'(STARVE_LIMIT))
      starve_q <= starve_q + 4'd1;
  end

  mem_arbiter_fifo #(
    .WIDTH (1),
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (bus_gnt),
    .push_dat (owner == OWN_DATA),
    .pop      (rsp_vld),
    .head_dat (head_id),
    .count    (count)
  );

  // Responses with nothing outstanding are stray and silently dropped.
  assign rsp_vld    = !rst && mem_rvalid_i && (count != '0);
  assign head_owner = owner_e'(head_id);

  assign instr_rvalid_o = rsp_vld && (head_owner == OWN_INSTR);
  assign data_rvalid_o  = rsp_vld && (head_owner == OWN_DATA);
  assign instr_rdata_o  = mem_rdata_i;
  assign data_rdata_o   = mem_rdata_i;
  assign instr_err_o    = mem_err_i;
  assign data_err_o     = mem_err_i;
endmodule
